// File: rtl/circ_mtx_vec_mul_seq_if.sv
// Operand/result handshake bundle for circ_mtx_vec_mul_seq.
// slave = the multiplier; master = whatever feeds it and drains its result.
interface circ_mtx_vec_mul_seq_if #(
    parameter int WIDTH = 31,
    parameter int N     = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] mtx_row;
    logic [N*WIDTH-1:0] vec;
    logic               out_valid;
    logic               out_ready;
    logic [N*WIDTH-1:0] result;
    logic               busy;

    modport slave (
        input  in_valid, mtx_row, vec, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, mtx_row, vec, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/circ_mtx_vec_mul_seq.sv
// Sequential circulant matrix-vector multiplier over GF(2^WIDTH - 1), LANES rows per pass.
// Define CIRC_MTX_ROW_LATCH_EN to capture mtx_row on accept; otherwise it must stay stable until out_valid.
module circ_mtx_vec_mul_seq #(
    parameter int WIDTH = 31,
    parameter int N     = 16,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    circ_mtx_vec_mul_seq_if.slave  bus
);
    localparam int GROUPS = N / LANES;
    localparam int JW     = (N > 1) ? $clog2(N) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [WIDTH-1:0] P = {WIDTH{1'b1}};

    generate
        if (N % LANES != 0) begin : g_bad_lanes
            $fatal(1, "circ_mtx_vec_mul_seq: N must be a multiple of LANES");
        end
        if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "circ_mtx_vec_mul_seq: WIDTH must be in 8..32");
        end
        if (N < 2) begin : g_bad_n
            $fatal(1, "circ_mtx_vec_mul_seq: N must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    // The all-ones encoding is the second representation of zero.
    function automatic logic [WIDTH-1:0] canon(input logic [WIDTH-1:0] x);
        return (x == P) ? '0 : x;
    endfunction

    // Folds the carry of s back in and maps p to 0; valid for s <= 2^(WIDTH+1) - 2.
    function automatic logic [WIDTH-1:0] fold_sub(input logic [WIDTH:0] s);
        logic [WIDTH-1:0] t;
        t = s[WIDTH-1:0] + WIDTH'(s[WIDTH]);
        return (t == P) ? '0 : t;
    endfunction

    function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return fold_sub({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[WIDTH-1:0]});
    endfunction

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return fold_sub({1'b0, a} + {1'b0, b});
    endfunction

    // (j - i) mod N without a divider: j + N - i lies in [1, 2N-1].
    function automatic logic [JW-1:0] rot_idx(input logic [JW-1:0] jj,
                                              input logic [JW-1:0] ii);
        logic [JW:0] t;
        t = {1'b0, jj} + (JW+1)'(N) - {1'b0, ii};
        return (t >= (JW+1)'(N)) ? JW'(t - (JW+1)'(N)) : t[JW-1:0];
    endfunction

    state_t             state, state_nxt;
    logic [JW-1:0]      j;
    logic [GW-1:0]      g;
    logic               j_last, g_last, accept;
    logic               in_rdy, out_vld, busy_o;
    logic [N*WIDTH-1:0] v_q;
    logic [N*WIDTH-1:0] c_src;
    logic [N*WIDTH-1:0] res_flat;
    logic [WIDTH-1:0]   c_arr   [N];
    logic [WIDTH-1:0]   res_q   [N];
    logic [WIDTH-1:0]   acc     [LANES];
    logic [WIDTH-1:0]   acc_sum [LANES];
    logic [JW-1:0]      row_idx [LANES];
    logic [WIDTH-1:0]   v_j;

`ifdef CIRC_MTX_ROW_LATCH_EN
    logic [N*WIDTH-1:0] c_q;
    always_ff @(posedge clk) begin
        if (accept) c_q <= bus.mtx_row;
    end
    assign c_src = c_q;
`else
    assign c_src = bus.mtx_row;
`endif

    // Operand capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) v_q <= bus.vec;
    end

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign c_arr[k] = canon(c_src[k*WIDTH +: WIDTH]);
    end

    always_comb begin
        res_flat = '0;
        for (int k = 0; k < N; k++) res_flat[k*WIDTH +: WIDTH] = res_q[k];
    end

    assign j_last = (j == JW'(N - 1));
    assign g_last = (g == GW'(GROUPS - 1));
    assign v_j    = canon(v_q[j*WIDTH +: WIDTH]);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            row_idx[l] = JW'(int'(g) * LANES + l);
            acc_sum[l] = mod_add(acc[l], mod_mul(c_arr[rot_idx(j, row_idx[l])], v_j));
        end
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        busy_o    = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = !rst;
                if (bus.in_valid && !rst) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy_o = 1'b1;
                if (j_last && g_last) state_nxt = DONE;
            end
            DONE: begin
                busy_o  = 1'b1;
                out_vld = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept        = bus.in_valid && in_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.busy      = busy_o;
    assign bus.result    = res_flat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            j     <= '0;
            g     <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            for (int k = 0; k < N; k++) res_q[k] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                j <= '0;
                g <= '0;
                for (int l = 0; l < LANES; l++) acc[l] <= '0;
            end else if (state == COMPUTE) begin
                // Row complete: this cycle's term is already in acc_sum.
                if (j_last) begin
                    j <= '0;
                    g <= g_last ? '0 : g + GW'(1);
                    for (int l = 0; l < LANES; l++) begin
                        res_q[row_idx[l]] <= acc_sum[l];
                        acc[l]            <= '0;
                    end
                end else begin
                    j <= j + JW'(1);
                    for (int l = 0; l < LANES; l++) acc[l] <= acc_sum[l];
                end
            end
        end
    end
endmodule

// File: tb/tb_circ_mtx_vec_mul_seq.sv
// Directed bench for circ_mtx_vec_mul_seq (N=16, WIDTH=31, LANES=4, row latch disabled).
// Latency is counted in clock edges with the accept edge counted as the first.
module tb_circ_mtx_vec_mul_seq;
    localparam int WIDTH = 31;
    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int LAT   = N * N / LANES + 1;
    localparam logic [WIDTH-1:0] P = {WIDTH{1'b1}};

    typedef logic [511:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    circ_mtx_vec_mul_seq_if #(.WIDTH(WIDTH), .N(N)) bus_if ();

    circ_mtx_vec_mul_seq #(.WIDTH(WIDTH), .N(N), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0]   c_arr [N];
    logic [WIDTH-1:0]   v_arr [N];
    logic [WIDTH-1:0]   e_arr [N];
    logic [N*WIDTH-1:0] exp_flat;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_operands();
        for (int k = 0; k < N; k++) begin
            bus_if.mtx_row[k*WIDTH +: WIDTH] = c_arr[k];
            bus_if.vec[k*WIDTH +: WIDTH]     = v_arr[k];
            exp_flat[k*WIDTH +: WIDTH]       = e_arr[k];
        end
    endtask

    task automatic start_txn(input string tag);
        @(negedge clk);
        drive_operands();
        check({tag, "_in_ready"}, word_t'(bus_if.in_ready), word_t'(1));
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 1;
        while (!bus_if.out_valid && lat < 4 * LAT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, word_t'(lat), word_t'(LAT));
    endtask

    task automatic check_result(input string tag);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_r%0d", tag, k),
                  word_t'(bus_if.result[k*WIDTH +: WIDTH]), word_t'(e_arr[k]));
    endtask

    task automatic run(input string tag);
        start_txn(tag);
        wait_done(tag);
        check_result(tag);
        @(posedge clk);
        #1;
        check({tag, "_release"}, word_t'({bus_if.busy, bus_if.out_valid}), word_t'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.mtx_row   = '0;
        bus_if.vec       = '0;
        exp_flat         = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  word_t'(bus_if.in_ready),  word_t'(0));
        check("rst_out_valid", word_t'(bus_if.out_valid), word_t'(0));
        check("rst_busy",      word_t'(bus_if.busy),      word_t'(0));
        check("rst_result",    word_t'(bus_if.result),    word_t'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", word_t'(bus_if.in_ready), word_t'(1));

        // Identity row: r = v.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = (k == 0) ? WIDTH'(1) : '0;
            v_arr[k] = WIDTH'(k);
            e_arr[k] = WIDTH'(k);
        end
        run("ident");

        // c[1] = 1 selects v[i+1] for row i, wrapping at the end.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = (k == 1) ? WIDTH'(1) : '0;
            v_arr[k] = WIDTH'(32'h100 + k);
            e_arr[k] = WIDTH'(32'h100 + ((k + 1) % N));
        end
        run("shift");

        // (p-1) * 2 = 2p - 2 = p - 2.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = (k == 0) ? 31'h7FFF_FFFE : '0;
            v_arr[k] = 31'd2;
            e_arr[k] = 31'h7FFF_FFFD;
        end
        run("red_pm1");

        // All-ones operands are zero.
        for (int k = 0; k < N; k++) begin
            v_arr[k] = P;
            e_arr[k] = '0;
        end
        run("red_noncanon_v");

        // 2^30 * 4 = 2^32 = 2 mod (2^31 - 1).
        for (int k = 0; k < N; k++) begin
            c_arr[k] = (k == 0) ? 31'h4000_0000 : '0;
            v_arr[k] = 31'd4;
            e_arr[k] = 31'd2;
        end
        run("red_pow2");

        // Sixteen 1*1 terms.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = 31'd1;
            v_arr[k] = 31'd1;
            e_arr[k] = 31'd16;
        end
        run("sum_ones");

        // (p-1)^2 = 1, summed sixteen times.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = 31'h7FFF_FFFE;
            v_arr[k] = 31'h7FFF_FFFE;
            e_arr[k] = 31'd16;
        end
        run("sum_pm1");

        // Non-canonical matrix entries vanish; only c[1] = 3 contributes.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = (k == 1) ? 31'd3 : P;
            v_arr[k] = 31'd5;
            e_arr[k] = 31'd15;
        end
        run("noncanon_c");

        // Two-tap row under backpressure, with in_valid pulsed while busy.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = (k == 0) ? 31'd1 : (k == 1) ? 31'd2 : '0;
            v_arr[k] = WIDTH'(k + 1);
            e_arr[k] = WIDTH'((k + 1) + 2 * (((k + 1) % N) + 1));
        end
        bus_if.out_ready = 1'b0;
        start_txn("bp");
        @(negedge clk);
        bus_if.vec      = {N{31'h2AAA_AAAA}};
        bus_if.in_valid = 1'b1;
        wait_done("bp");
        check_result("bp");
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            bus_if.in_valid = cyc[0];
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid_%0d", cyc),  word_t'(bus_if.out_valid), word_t'(1));
            check($sformatf("bp_hold_ready_%0d", cyc),  word_t'(bus_if.in_ready),  word_t'(0));
            check($sformatf("bp_hold_result_%0d", cyc), word_t'(bus_if.result),    word_t'(exp_flat));
        end
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_busy",  word_t'(bus_if.busy),     word_t'(0));
        check("bp_release_ready", word_t'(bus_if.in_ready), word_t'(1));

        // Abort mid-compute; rows 0..3 are already written by then.
        for (int k = 0; k < N; k++) begin
            c_arr[k] = (k == 0) ? WIDTH'(1) : '0;
            v_arr[k] = WIDTH'(k + 1);
            e_arr[k] = WIDTH'(k + 1);
        end
        start_txn("abort");
        repeat (19) @(posedge clk);
        #1;
        check("abort_partial_r1", word_t'(bus_if.result[1*WIDTH +: WIDTH]), word_t'(2));
        check("abort_busy_before", word_t'(bus_if.busy), word_t'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", word_t'(bus_if.out_valid), word_t'(0));
        check("abort_busy",      word_t'(bus_if.busy),      word_t'(0));
        check("abort_result",    word_t'(bus_if.result),    word_t'(0));
        check("abort_in_ready",  word_t'(bus_if.in_ready),  word_t'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < N; k++) begin
            v_arr[k] = WIDTH'(k);
            e_arr[k] = WIDTH'(k);
        end
        run("ident_after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
